// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game engine.
package mole_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Fibonacci feedback from bits 16,14,13,11 (1-based numbering).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  // Bumping a collision by one hole guarantees the mole never reappears in the same place.
  function automatic int unsigned next_pos(input logic [15:0] lfsr, input int unsigned cur,
                                           input int unsigned n_holes);
    int unsigned pos;
    pos = 32'(lfsr) % n_holes;
    if (pos == cur) pos = (pos + 1) % n_holes;
    return pos;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating BCD score counter: clear to zero, count up to all-9s, count down to zero.
// Neither direction ever wraps.
module bcd_counter
  import mole_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  input  logic                      dec,
  output logic [4*SCORE_DIGITS-1:0] value
);

  bcd_digit_t [SCORE_DIGITS-1:0] digits_q, digits_d;
  logic                          all_nine, all_zero, ripple;

  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (digits_q[i] != 4'd9) all_nine = 1'b0;
      if (digits_q[i] != 4'd0) all_zero = 1'b0;
    end
  end

  // ripple is the carry when counting up and the borrow when counting down
  always_comb begin
    digits_d = digits_q;
    ripple   = 1'b1;
    if (clr) begin
      digits_d = '0;
    end else if (inc && !all_nine) begin
      for (int i = 0; i < SCORE_DIGITS; i++) begin
        if (ripple) begin
          if (digits_q[i] == 4'd9) begin
            digits_d[i] = 4'd0;
          end else begin
            digits_d[i] = digits_q[i] + 4'd1;
            ripple      = 1'b0;
          end
        end
      end
    end else if (dec && !all_zero) begin
      for (int i = 0; i < SCORE_DIGITS; i++) begin
        if (ripple) begin
          if (digits_q[i] == 4'd0) begin
            digits_d[i] = 4'd9;
          end else begin
            digits_d[i] = digits_q[i] - 4'd1;
            ripple      = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign value = digits_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game engine: round and mole timers, LFSR mole placement, BCD score.
// Define MOLE_MISS_PENALTY_EN to make each miss take one point off the score (floor 0).
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned N_HOLES      = 8,
  parameter int unsigned SCORE_DIGITS = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned MOLE_TICKS   = 1500,
  parameter int unsigned ROUND_TICKS  = 30000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       guess_valid,
  input  logic [$clog2(N_HOLES)-1:0] guess_idx,
  output logic [N_HOLES-1:0]         mole_onehot,
  output logic                       hit,
  output logic                       miss,
  output logic                       mole_timeout,
  output logic [4*SCORE_DIGITS-1:0]  score_bcd,
  output logic                       game_over
);

  localparam int unsigned IdxW = $clog2(N_HOLES);
  localparam int unsigned PreW = $clog2(TICK_DIV + 1);
  localparam int unsigned MolW = $clog2(MOLE_TICKS + 1);
  localparam int unsigned RndW = $clog2(ROUND_TICKS + 1);

  game_state_t     state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic [MolW-1:0] mole_t_q, mole_t_d;
  logic [RndW-1:0] round_q, round_d;
  logic [IdxW-1:0] mole_q, mole_d, drawn;
  logic            hit_q, miss_q, timeout_q;

  logic in_play, tick, mole_expire, round_end, enter_play;
  logic is_hit, is_miss, do_timeout, score_dec;

  always_comb begin
    in_play     = (state_q == PLAY);
    tick        = in_play && (presc_q == PreW'(TICK_DIV - 1));
    mole_expire = tick && (mole_t_q == MolW'(1));
    round_end   = tick && (round_q == RndW'(1));
    enter_play  = !in_play && start;
    // mole_q is always a valid hole, so out-of-range guesses land here as misses
    is_hit      = in_play && guess_valid && (guess_idx == mole_q);
    is_miss     = in_play && guess_valid && (guess_idx != mole_q);
    do_timeout  = mole_expire && !(in_play && guess_valid);
    drawn       = IdxW'(next_pos(lfsr_q, 32'(mole_q), N_HOLES));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PLAY;
      PLAY:    if (round_end) state_d = OVER;
      OVER:    if (start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mole_onehot = '0;
    if (in_play) mole_onehot[mole_q] = 1'b1;
    game_over    = (state_q == OVER);
    hit          = hit_q;
    miss         = miss_q;
    mole_timeout = timeout_q;
  end

  always_comb begin
    lfsr_d   = lfsr_step(lfsr_q);
    presc_d  = presc_q;
    mole_t_d = mole_t_q;
    round_d  = round_q;
    mole_d   = mole_q;
    if (enter_play) begin
      presc_d  = '0;
      mole_t_d = MolW'(MOLE_TICKS);
      round_d  = RndW'(ROUND_TICKS);
      mole_d   = drawn;
    end else if (in_play) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) round_d = round_q - 1'b1;
      if (is_hit || do_timeout) mole_d = drawn;
      // An expiry swallowed by a miss still restarts the mole timer.
      if (is_hit || mole_expire) begin
        mole_t_d = MolW'(MOLE_TICKS);
      end else if (tick) begin
        mole_t_d = mole_t_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= LFSR_SEED;
      presc_q   <= '0;
      mole_t_q  <= '0;
      round_q   <= '0;
      mole_q    <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      presc_q   <= presc_d;
      mole_t_q  <= mole_t_d;
      round_q   <= round_d;
      mole_q    <= mole_d;
      hit_q     <= is_hit;
      miss_q    <= is_miss;
      timeout_q <= do_timeout;
    end
  end

`ifdef MOLE_MISS_PENALTY_EN
  assign score_dec = is_miss;
`else
  assign score_dec = 1'b0;
`endif

  bcd_counter #(
    .SCORE_DIGITS(SCORE_DIGITS)
  ) u_score (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter_play),
    .inc  (is_hit),
    .dec  (score_dec),
    .value(score_bcd)
  );

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: random guesses checked against a cycle-indexed game model
// that tracks absolute tick deadlines and integer scores.
module tb_mole_game_ctrl;

  localparam int N  = 8;
  localparam int TD = 4;
  localparam int MT = 3;
  localparam int RT = 20;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic [2:0] guess_idx = 3'd0;
  logic [7:0] mole_onehot, mole_onehot_s;
  logic       hit, miss, mole_timeout, game_over;
  logic       hit_s, miss_s, mole_timeout_s, game_over_s;
  logic [15:0] score_bcd;
  logic [3:0]  score_s;

  int n_checks = 0;
  int n_errors = 0;

  mole_game_ctrl #(
    .N_HOLES(N), .SCORE_DIGITS(4), .TICK_DIV(TD), .MOLE_TICKS(MT), .ROUND_TICKS(RT),
    .LFSR_SEED(SEED)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid), .guess_idx(guess_idx),
    .mole_onehot(mole_onehot), .hit(hit), .miss(miss), .mole_timeout(mole_timeout),
    .score_bcd(score_bcd), .game_over(game_over)
  );

  // Single-digit score instance reaches saturation within one short round.
  mole_game_ctrl #(
    .N_HOLES(N), .SCORE_DIGITS(1), .TICK_DIV(TD), .MOLE_TICKS(MT), .ROUND_TICKS(RT),
    .LFSR_SEED(SEED)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid), .guess_idx(guess_idx),
    .mole_onehot(mole_onehot_s), .hit(hit_s), .miss(miss_s), .mole_timeout(mole_timeout_s),
    .score_bcd(score_s), .game_over(game_over_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        play;
    logic        over;
    int          cyc;    // cycle index since the first PLAY cycle
    int          mole;
    int          dl;     // cycle index in which the current mole expires
    int          s4;
    int          s1;
    logic [15:0] lfsr;
    logic        hit;
    logic        miss;
    logic        to;
  } model_t;

  model_t m;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  function automatic int draw(input logic [15:0] lfsr, input int cur);
    int p;
    p = int'(lfsr) % N;
    if (p == cur) p = (p + 1) % N;
    return p;
  endfunction

  // Ticks land on cycles with index % TD == TD-1; a mole (re)armed in cycle c dies on
  // the MT-th tick strictly after c.
  function automatic int deadline(input int c);
    int first;
    first = ((c + 1) / TD) * TD + TD - 1;
    return first + (MT - 1) * TD;
  endfunction

  function automatic model_t model_next(input model_t x, input logic r, input logic s,
                                        input logic gv, input logic [2:0] gi);
    model_t n;
    logic   exp_now, rend;
    n = x;
    if (r) begin
      n = '0;
      n.lfsr = SEED;
      return n;
    end
    n.hit = 1'b0;
    n.miss = 1'b0;
    n.to = 1'b0;
    if (!x.play) begin
      if (s) begin
        n.play = 1'b1;
        n.over = 1'b0;
        n.cyc  = 0;
        n.s4   = 0;
        n.s1   = 0;
        n.mole = draw(x.lfsr, x.mole);
        n.dl   = deadline(-1);
      end
    end else begin
      exp_now = (x.cyc == x.dl);
      rend    = (x.cyc == RT * TD - 1);
      if (gv) begin
        if (int'(gi) == x.mole) begin
          n.hit  = 1'b1;
          n.s4   = (x.s4 < 9999) ? x.s4 + 1 : 9999;
          n.s1   = (x.s1 < 9) ? x.s1 + 1 : 9;
          n.mole = draw(x.lfsr, x.mole);
          n.dl   = deadline(x.cyc);
        end else begin
          n.miss = 1'b1;
`ifdef MOLE_MISS_PENALTY_EN
          n.s4 = (x.s4 > 0) ? x.s4 - 1 : 0;
          n.s1 = (x.s1 > 0) ? x.s1 - 1 : 0;
`endif
          if (exp_now) n.dl = deadline(x.cyc);
        end
      end else if (exp_now) begin
        n.to   = 1'b1;
        n.mole = draw(x.lfsr, x.mole);
        n.dl   = deadline(x.cyc);
      end
      n.cyc = x.cyc + 1;
      if (rend) begin
        n.play = 1'b0;
        n.over = 1'b1;
      end
    end
    n.lfsr = lfsr_next(x.lfsr);
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, start, guess_valid, guess_idx);

  function automatic logic [7:0] exp_onehot(input model_t x);
    return x.play ? (8'd1 << x.mole) : 8'd0;
  endfunction

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] wrong_idx(input int mole);
    return 3'((mole + 1 + int'($urandom_range(0, N - 2))) % N);
  endfunction

  // Drive inputs at a falling edge and advance to the next falling edge.
  task automatic step(input logic s, input logic gv, input logic [2:0] gi);
    start = s;
    guess_valid = gv;
    guess_idx = gi;
    @(negedge clk);
  endtask

  task automatic restart();
    rst = 1'b1;
    step(1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0, 3'd0);
    n_checks++;
    if (score_bcd !== 16'h0000) begin
      n_errors++; $display("FAIL reset_score: got %h want 0000", score_bcd);
    end
    n_checks++;
    if (mole_onehot !== 8'h00) begin
      n_errors++; $display("FAIL reset_mole: got %b want 00000000", mole_onehot);
    end
    n_checks++;
    if ({hit, miss, mole_timeout, game_over} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags: got %b want 0000",
                           {hit, miss, mole_timeout, game_over});
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_play();
    restart();
    repeat (10) step(1'b0, 1'b1, 3'(m.mole));
    n_checks++;
    if (score_bcd !== to_bcd4(m.s4) || score_bcd === 16'h0000) begin
      n_errors++; $display("FAIL midplay_score: got %h want %h", score_bcd, to_bcd4(m.s4));
    end
    rst = 1'b1;
    step(1'b0, 1'b1, 3'(m.mole));
    n_checks++;
    if (hit !== 1'b0) begin
      n_errors++; $display("FAIL rst_hit_suppressed: got %b want 0", hit);
    end
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    n_checks++;
    if ({score_bcd, mole_onehot, game_over} !== 25'd0) begin
      n_errors++; $display("FAIL midplay_rst: got score=%h mole=%b over=%b want all 0",
                           score_bcd, mole_onehot, game_over);
    end
    rst = 1'b0;
  endtask

  task automatic test_hit();
    int old;
    restart();
    old = m.mole;
    n_checks++;
    if (mole_onehot !== exp_onehot(m)) begin
      n_errors++; $display("FAIL first_mole: got %b want %b", mole_onehot, exp_onehot(m));
    end
    step(1'b0, 1'b1, 3'(old));
    n_checks++;
    if (hit !== 1'b1 || miss !== 1'b0) begin
      n_errors++; $display("FAIL hit_pulse: got hit=%b miss=%b want 1 0", hit, miss);
    end
    n_checks++;
    if (score_bcd !== 16'h0001) begin
      n_errors++; $display("FAIL hit_score: got %h want 0001", score_bcd);
    end
    n_checks++;
    if (mole_onehot === (8'd1 << old) || !$onehot(mole_onehot)) begin
      n_errors++; $display("FAIL new_mole: got %b want one-hot other than %0d", mole_onehot, old);
    end
    n_checks++;
    if (mole_onehot !== exp_onehot(m)) begin
      n_errors++; $display("FAIL hit_mole: got %b want %b", mole_onehot, exp_onehot(m));
    end
  endtask

  task automatic test_miss();
    logic [15:0] want;
    restart();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, wrong_idx(m.mole));
      n_checks++;
      if (miss !== 1'b1 || hit !== 1'b0) begin
        n_errors++; $display("FAIL miss_pulse[%0d]: got miss=%b hit=%b want 1 0", i, miss, hit);
      end
    end
    n_checks++;
    if (score_bcd !== 16'h0000) begin
      n_errors++; $display("FAIL miss_floor: got %h want 0000", score_bcd);
    end
    repeat (3) step(1'b0, 1'b1, 3'(m.mole));
    step(1'b0, 1'b1, wrong_idx(m.mole));
`ifdef MOLE_MISS_PENALTY_EN
    want = 16'h0002;
`else
    want = 16'h0003;
`endif
    n_checks++;
    if (score_bcd !== want) begin
      n_errors++; $display("FAIL hits_then_miss: got %h want %h", score_bcd, want);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] prev;
    restart();
    for (int k = 1; k <= 40; k++) begin
      prev = mole_onehot;
      step(1'b0, 1'b0, 3'd0);
      n_checks++;
      if (mole_timeout !== (k % 12 == 0)) begin
        n_errors++; $display("FAIL timeout_k%0d: got %b want %b", k, mole_timeout, k % 12 == 0);
      end
      n_checks++;
      if (mole_onehot !== exp_onehot(m) || score_bcd !== 16'h0000) begin
        n_errors++; $display("FAIL timeout_state_k%0d: got mole=%b score=%h want %b 0000",
                             k, mole_onehot, score_bcd, exp_onehot(m));
      end
      if (k % 12 == 0) begin
        n_checks++;
        if (mole_onehot === prev) begin
          n_errors++; $display("FAIL timeout_redraw_k%0d: got %b want change", k, mole_onehot);
        end
      end
    end
  endtask

  task automatic test_collide_saturate();
    restart();
    repeat (11) step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'(m.mole));
    n_checks++;
    if (hit !== 1'b1 || mole_timeout !== 1'b0) begin
      n_errors++; $display("FAIL collide: got hit=%b timeout=%b want 1 0", hit, mole_timeout);
    end
    repeat (11) step(1'b0, 1'b0, 3'd0);
    n_checks++;
    if (mole_timeout !== 1'b0) begin
      n_errors++; $display("FAIL reload_early: got %b want 0", mole_timeout);
    end
    step(1'b0, 1'b0, 3'd0);
    n_checks++;
    if (mole_timeout !== 1'b1) begin
      n_errors++; $display("FAIL reload_expiry: got %b want 1", mole_timeout);
    end
    repeat (12) step(1'b0, 1'b1, 3'(m.mole));
    n_checks++;
    if (score_s !== 4'h9 || hit_s !== 1'b1) begin
      n_errors++; $display("FAIL saturate: got score=%h hit=%b want 9 1", score_s, hit_s);
    end
    n_checks++;
    if (score_bcd !== 16'h0013) begin
      n_errors++; $display("FAIL multi_digit: got %h want 0013", score_bcd);
    end
  endtask

  task automatic test_round_over();
    logic [15:0] held;
    logic        gv;
    restart();
    for (int k = 1; k <= 80; k++) begin
      gv = 1'($urandom_range(0, 1));
      step(1'b0, gv, ($urandom_range(0, 1) == 1) ? 3'(m.mole) : 3'($urandom_range(0, 7)));
      if (k == 79) begin
        n_checks++;
        if (game_over !== 1'b0) begin
          n_errors++; $display("FAIL over_early: got %b want 0", game_over);
        end
      end
    end
    n_checks++;
    if (game_over !== 1'b1 || mole_onehot !== 8'h00) begin
      n_errors++; $display("FAIL over: got over=%b mole=%b want 1 00000000",
                           game_over, mole_onehot);
    end
    held = to_bcd4(m.s4);
    n_checks++;
    if (score_bcd !== held) begin
      n_errors++; $display("FAIL over_score: got %h want %h", score_bcd, held);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'($urandom_range(0, 7)));
      n_checks++;
      if (hit !== 1'b0 || miss !== 1'b0 || score_bcd !== held) begin
        n_errors++; $display("FAIL over_ignore[%0d]: got hit=%b miss=%b score=%h want 0 0 %h",
                             i, hit, miss, score_bcd, held);
      end
    end
    step(1'b1, 1'b0, 3'd0);
    n_checks++;
    if (game_over !== 1'b0 || score_bcd !== 16'h0000 || !$onehot(mole_onehot)) begin
      n_errors++; $display("FAIL replay: got over=%b score=%h mole=%b want 0 0000 one-hot",
                           game_over, score_bcd, mole_onehot);
    end
  endtask

  task automatic test_random();
    logic gv, s;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 19) == 0);
      gv  = 1'($urandom_range(0, 1));
      step(s, gv, ($urandom_range(0, 1) == 1) ? 3'(m.mole) : 3'($urandom_range(0, 7)));
      n_checks++;
      if (mole_onehot !== exp_onehot(m)) begin
        n_errors++; $display("FAIL rnd_mole[%0d]: got %b want %b", i, mole_onehot, exp_onehot(m));
      end
      n_checks++;
      if ({hit, miss, mole_timeout} !== {m.hit, m.miss, m.to}) begin
        n_errors++; $display("FAIL rnd_pulses[%0d]: got %b want %b", i,
                             {hit, miss, mole_timeout}, {m.hit, m.miss, m.to});
      end
      n_checks++;
      if (score_bcd !== to_bcd4(m.s4) || score_s !== 4'(m.s1)) begin
        n_errors++; $display("FAIL rnd_score[%0d]: got %h/%h want %h/%h", i, score_bcd,
                             score_s, to_bcd4(m.s4), 4'(m.s1));
      end
      n_checks++;
      if (game_over !== m.over) begin
        n_errors++; $display("FAIL rnd_over[%0d]: got %b want %b", i, game_over, m.over);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid_play();
    test_hit();
    test_miss();
    test_timeout();
    test_collide_saturate();
    test_round_over();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
